simd_cond_unit: RTL and testbench
=================================

SIMD_COND_UNIT -- requirements
Module: simd_cond_unit

Interface
REQ-001 SHALL have parameter LANES, default 4, number of SIMD lanes, legal 1..8.
REQ-002 SHALL have parameter COND_ALL, default 0. At 0, the condition applies to branches only. At 1, it applies to every instruction.
REQ-003 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_e  in  1  an execute-stage instruction is present.
- stall  in  1  execute stage held; no state update.
- flush  in  1  execute-stage instruction squashed.
- branch_e  in  1  the instruction is a branch.
- cond_e  in  4  condition code.
- flags_write  in  2  bit1 enables N,Z; bit0 enables C,V.
- scalar_mode  in  1  lane-0 predicate governs all lanes.
- alu_flags  in  4*LANES  per-lane {N,Z,C,V}; lane i at bits [4i+3:4i].
- sat  in  LANES  per-lane saturation event.
- clr_sat  in  1  clears all sticky saturation bits.
- cond_ex  out  1  lane-0 predicate, for branch resolution.
- pred_mask  out  LANES  per-lane execute/writeback enable.
- flags_q  out  4*LANES  registered per-lane {N,Z,C,V}.
- sat_q  out  LANES  sticky per-lane saturation bits.

Function
REQ-004 SHALL hold one 4-bit {N,Z,C,V} register per lane, with GE = (N==V).
REQ-005 SHALL compute effective condition code ec = cond_e when (branch_e | COND_ALL), else 4'b0000.
REQ-006 SHALL evaluate raw per-lane predicate p[i] from that lane's registered flags:
- 0000 always
- 0001 Z; 0010 ~Z
- 0011 ~Z&GE; 0100 GE; 0101 ~GE; 0110 ~(~Z&GE)
- 0111 C; 1000 ~C; 1001 N; 1010 ~N; 1011 V; 1100 ~V
- 1101 C&~Z; 1110 ~(C&~Z)
- 1111 never (0); no X output for any code.
REQ-007 SHALL, when scalar_mode=1, replace every p[i] with p[0].
REQ-008 SHALL drive pred_mask[i] = p[i] & valid_e & ~flush, combinationally (zero latency) from registered flags and current inputs.
REQ-009 SHALL drive cond_ex = pred_mask[0].
REQ-010 SHALL define update enable u = valid_e & ~stall & ~flush. Priority: flush over stall over update.
REQ-011 SHALL, on a rising edge with u=1, for each lane with pred_mask[i]=1, load N,Z from alu_flags if flags_write[1] and C,V if flags_write[0]; all other flag bits hold.
REQ-012 SHALL hold all flags when u=0 or pred_mask[i]=0.
REQ-013 SHALL make an update visible to the next instruction one cycle later; there is no same-cycle bypass.
REQ-014 SHALL set sat_q[i] on an edge when u & pred_mask[i] & sat[i].
REQ-015 SHALL clear all sat_q on an edge when clr_sat=1 and the set condition of REQ-014 is false for that lane; a coincident set wins over clear.
REQ-016 SHALL ignore sat and flags_write while stall or flush is asserted. clr_sat acts regardless of stall or flush.
REQ-017 SHALL give lanes fully independent state; no cross-lane interaction except under scalar_mode.

Reset
REQ-018 SHALL, while rst_n=0, force flags_q=0 and sat_q=0 immediately, independent of clk.
REQ-019 SHALL, during reset, produce outputs that follow REQ-008 from zeroed flags. EQ evaluates false; NE, always and GE evaluate true.
REQ-020 SHALL abandon any in-progress update when reset asserts mid-operation; the first update after release uses the inputs present at that edge.

Verification (LANES=4, COND_ALL=0)
REQ-021 SHALL cover:
- Reset, then branch_e=1, cond_e=0001, valid_e=1 -> cond_ex=0, pred_mask=0000. With cond_e=0010 -> pred_mask=1111.
- Two cycles back to back:
  - cycle 1: valid_e=1, branch_e=0, flags_write=11, alu_flags={lane3 0100, lane2 0000, lane1 0100, lane0 1000}.
  - cycle 2: branch_e=1, cond_e=0001 -> pred_mask=1010.
  - Same cycle 2 with scalar_mode=1 -> pred_mask=0000.
- Flag write with stall=1 or flush=1 -> flags_q unchanged. Same write with both deasserted -> updated next cycle.
- flags_write=10 with alu_flags all 1111 from zero -> every lane's flags_q=1100 (C,V held at 0).
- sat=0101 with u=1 -> sat_q=0101. Then clr_sat=1 with sat=0001 on the same edge -> sat_q=0001.
- Reset asserted asynchronously between edges while flags are nonzero -> flags_q=0 and sat_q=0 before the next clk edge. cond_e=1111 -> pred_mask=0000.

Source files
------------

// File: rtl/simd_cond_unit.sv
// Per-lane SIMD condition unit. Predicates are combinational from registered NZCV. Flag and saturation updates land on the next edge.
// No backpressure path: stall freezes state, flush squashes the mask, and clr_sat ignores both.
module simd_cond_unit #(
  parameter int LANES    = 4,
  parameter bit COND_ALL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_e,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 branch_e,
  input  logic [3:0]           cond_e,
  input  logic [1:0]           flags_write,
  input  logic                 scalar_mode,
  input  logic [4*LANES-1:0]   alu_flags,
  input  logic [LANES-1:0]     sat,
  input  logic                 clr_sat,
  output logic                 cond_ex,
  output logic [LANES-1:0]     pred_mask,
  output logic [4*LANES-1:0]   flags_q,
  output logic [LANES-1:0]     sat_q
);

  logic [3:0]       ec;
  logic [LANES-1:0] p_raw;
  logic [LANES-1:0] p_sel;
  logic [LANES-1:0] sat_set;
  logic             upd;

  // f is {N,Z,C,V}; unlisted codes never reach here since all 16 are decoded.
  function automatic logic eval_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, ge;
    n  = f[3];
    z  = f[2];
    c  = f[1];
    v  = f[0];
    ge = (n == v);
    case (cc)
      4'b0000: eval_cond = 1'b1;
      4'b0001: eval_cond = z;
      4'b0010: eval_cond = ~z;
      4'b0011: eval_cond = ~z & ge;
      4'b0100: eval_cond = ge;
      4'b0101: eval_cond = ~ge;
      4'b0110: eval_cond = ~(~z & ge);
      4'b0111: eval_cond = c;
      4'b1000: eval_cond = ~c;
      4'b1001: eval_cond = n;
      4'b1010: eval_cond = ~n;
      4'b1011: eval_cond = v;
      4'b1100: eval_cond = ~v;
      4'b1101: eval_cond = c & ~z;
      4'b1110: eval_cond = ~(c & ~z);
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // Non-branch instructions run unconditionally unless every instruction is predicated.
  assign ec = (branch_e || COND_ALL) ? cond_e : 4'b0000;

  always_comb begin
    p_raw = '0;
    for (int i = 0; i < LANES; i++) begin
      p_raw[i] = eval_cond(ec, flags_q[4*i +: 4]);
    end
  end

  assign p_sel     = scalar_mode ? {LANES{p_raw[0]}} : p_raw;
  assign pred_mask = p_sel & {LANES{valid_e & ~flush}};
  assign cond_ex   = pred_mask[0];

  assign upd     = valid_e & ~stall & ~flush;
  assign sat_set = {LANES{upd}} & pred_mask & sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (upd) begin
      for (int i = 0; i < LANES; i++) begin
        if (pred_mask[i]) begin
          if (flags_write[1]) flags_q[4*i+3 -: 2] <= alu_flags[4*i+3 -: 2];
          if (flags_write[0]) flags_q[4*i+1 -: 2] <= alu_flags[4*i+1 -: 2];
        end
      end
    end
  end

  // A set in the same cycle as a clear wins, so no saturation event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (sat_set[i])   sat_q[i] <= 1'b1;
        else if (clr_sat) sat_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simd_cond_unit.sv
// Bench for simd_cond_unit (LANES=4, COND_ALL=0): a lane-level model is compared every cycle, and literal expectations pin it.
module tb_simd_cond_unit;
  localparam int LANES = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              valid_e = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              branch_e = 1'b0;
  logic [3:0]        cond_e = 4'b0000;
  logic [1:0]        flags_write = 2'b00;
  logic              scalar_mode = 1'b0;
  logic [4*LANES-1:0] alu_flags = '0;
  logic [LANES-1:0]  sat = '0;
  logic              clr_sat = 1'b0;
  logic              cond_ex;
  logic [LANES-1:0]  pred_mask;
  logic [4*LANES-1:0] flags_q;
  logic [LANES-1:0]  sat_q;

  simd_cond_unit #(.LANES(LANES), .COND_ALL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .stall(stall), .flush(flush),
    .branch_e(branch_e), .cond_e(cond_e), .flags_write(flags_write),
    .scalar_mode(scalar_mode), .alu_flags(alu_flags), .sat(sat), .clr_sat(clr_sat),
    .cond_ex(cond_ex), .pred_mask(pred_mask), .flags_q(flags_q), .sat_q(sat_q)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: one NZCV nibble per lane plus the sticky saturation bits.
  bit [3:0]       m_flags [LANES];
  bit [LANES-1:0] m_sat;

  function automatic bit cond_true(input bit [3:0] cc, input bit [3:0] nzcv);
    bit nf, zf, cf, vf, ge;
    {nf, zf, cf, vf} = nzcv;
    ge = (nf == vf);
    case (cc)
      4'd0:    return 1'b1;
      4'd1:    return zf;
      4'd2:    return !zf;
      4'd3:    return !zf && ge;
      4'd4:    return ge;
      4'd5:    return !ge;
      4'd6:    return !(!zf && ge);
      4'd7:    return cf;
      4'd8:    return !cf;
      4'd9:    return nf;
      4'd10:   return !nf;
      4'd11:   return vf;
      4'd12:   return !vf;
      4'd13:   return cf && !zf;
      4'd14:   return !(cf && !zf);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [LANES-1:0] exp_mask();
    bit [3:0]       ec;
    bit [LANES-1:0] p;
    ec = branch_e ? cond_e : 4'b0000;
    for (int i = 0; i < LANES; i++) p[i] = cond_true(ec, m_flags[i]);
    if (scalar_mode) p = {LANES{p[0]}};
    if (!valid_e || flush) p = '0;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit [LANES-1:0] pm;
    bit             upd;
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) m_flags[i] <= 4'b0000;
      m_sat <= '0;
    end else begin
      pm  = exp_mask();
      upd = valid_e && !stall && !flush;
      for (int i = 0; i < LANES; i++) begin
        if (upd && pm[i]) begin
          if (flags_write[1]) m_flags[i][3:2] <= alu_flags[4*i+3 -: 2];
          if (flags_write[0]) m_flags[i][1:0] <= alu_flags[4*i+1 -: 2];
        end
        if (upd && pm[i] && sat[i]) m_sat[i] <= 1'b1;
        else if (clr_sat)           m_sat[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit [LANES-1:0]   em;
    bit [4*LANES-1:0] ef;
    if (cmp_en) begin
      em = exp_mask();
      for (int i = 0; i < LANES; i++) ef[4*i +: 4] = m_flags[i];
      check("model_pred_mask", 32'(pred_mask), 32'(em));
      check("model_cond_ex", 32'(cond_ex), 32'(em[0]));
      check("model_flags_q", 32'(flags_q), 32'(ef));
      check("model_sat_q", 32'(sat_q), 32'(m_sat));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // While in reset: zero flags give EQ false, NE/GE/always true.
    valid_e = 1'b1; branch_e = 1'b1; cond_e = 4'b0001;
    #1;
    check("rst_eq_mask", 32'(pred_mask), 32'h0);
    check("rst_flags", 32'(flags_q), 32'h0);
    check("rst_sat", 32'(sat_q), 32'h0);
    cond_e = 4'b0010; #1 check("rst_ne_mask", 32'(pred_mask), 32'hF);
    cond_e = 4'b0100; #1 check("rst_ge_mask", 32'(pred_mask), 32'hF);
    cond_e = 4'b0000; #1 check("rst_al_mask", 32'(pred_mask), 32'hF);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    cond_e = 4'b0001; #1;
    check("eq_cond_ex", 32'(cond_ex), 32'h0);
    check("eq_mask", 32'(pred_mask), 32'h0);
    cond_e = 4'b0010; #1 check("ne_mask", 32'(pred_mask), 32'hF);

    // Back-to-back: write per-lane flags, then branch on EQ the next cycle.
    tick();
    branch_e = 1'b0; flags_write = 2'b11; alu_flags = 16'h4048;
    tick();
    branch_e = 1'b1; cond_e = 4'b0001; flags_write = 2'b00;
    #1;
    check("b2b_flags", 32'(flags_q), 32'h4048);
    check("b2b_eq_mask", 32'(pred_mask), 32'hA);
    check("b2b_cond_ex", 32'(cond_ex), 32'h0);
    scalar_mode = 1'b1; #1 check("b2b_scalar_mask", 32'(pred_mask), 32'h0);
    scalar_mode = 1'b0;

    tick();
    branch_e = 1'b0; flags_write = 2'b11; alu_flags = 16'hFFFF; sat = 4'hF; stall = 1'b1;
    tick();
    check("stall_hold_flags", 32'(flags_q), 32'h4048);
    check("stall_hold_sat", 32'(sat_q), 32'h0);
    stall = 1'b0; flush = 1'b1;
    tick();
    check("flush_hold_flags", 32'(flags_q), 32'h4048);
    check("flush_hold_sat", 32'(sat_q), 32'h0);
    flush = 1'b0; sat = 4'h0;
    tick();
    check("write_after_flags", 32'(flags_q), 32'hFFFF);

    // Only N,Z written from zeroed flags.
    flags_write = 2'b00; valid_e = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    valid_e = 1'b1; flags_write = 2'b10; alu_flags = 16'hFFFF;
    #2 rst_n = 1'b1;
    tick();
    check("nz_only_flags", 32'(flags_q), 32'hCCCC);
    flags_write = 2'b00;

    sat = 4'b0101;
    tick();
    check("sat_set", 32'(sat_q), 32'h5);
    sat = 4'b0001; clr_sat = 1'b1;
    tick();
    check("sat_clr_set_wins", 32'(sat_q), 32'h1);
    sat = 4'h0; clr_sat = 1'b0;

    // Asynchronous reset between edges with nonzero state.
    #1 rst_n = 1'b0;
    #1;
    check("async_flags", 32'(flags_q), 32'h0);
    check("async_sat", 32'(sat_q), 32'h0);
    branch_e = 1'b1; cond_e = 4'b1111;
    #1 check("async_nv_mask", 32'(pred_mask), 32'h0);
    branch_e = 1'b0; flags_write = 2'b11; alu_flags = 16'h1234;
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("post_reset_update", 32'(flags_q), 32'h1234);

    // Distinct per-lane flags, then sweep every code with scalar and control mixes.
    alu_flags = 16'h9A50;
    tick();
    flags_write = 2'b00; branch_e = 1'b1;
    cond_e = 4'b0100; #1 check("sweep_ge_mask", 32'(pred_mask), 32'h9);
    cond_e = 4'b1101; #1 check("sweep_hi_mask", 32'(pred_mask), 32'h4);
    for (int c = 0; c < 16; c++) begin
      for (int s = 0; s < 2; s++) begin
        cond_e = 4'(c);
        scalar_mode = 1'(s);
        valid_e = (c != 7);
        flush = (c == 9);
        stall = (c == 5);
        clr_sat = (c == 12);
        sat = 4'(c);
        tick();
      end
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
